// File: rtl/lsu_bridge.sv
// Load/store bridge between the core data port and a req/gnt/rvalid memory bus.
// Builds byte enables and replicated store lanes, formats load data, stalls the core.
//
// state | meaning
// IDLE  | waiting for a core access; captures it when read or write is seen
// REQ   | bus_req asserted with registered fields held until gnt
// WAIT  | granted; waiting for rvalid (read data or write ack)
// DONE  | one cycle with stall low; core_rdata / misalign valid
module lsu_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_core_mem_read,
   input  logic              i_core_mem_write,
   input  logic [2:0]        i_core_funct3,
   input  logic [ADDR_W-1:0] i_core_addr,
   input  logic [DATA_W-1:0] i_core_wdata,
   output logic [DATA_W-1:0] o_core_rdata,
   output logic              o_core_stall,
   output logic              o_misalign,
   output logic              o_bus_req,
   output logic              o_bus_we,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [3:0]        o_bus_be,
   output logic [DATA_W-1:0] o_bus_wdata,
   input  logic              i_bus_gnt,
   input  logic              i_bus_rvalid,
   input  logic [DATA_W-1:0] i_bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_offset;
   logic [2:0]          r_funct3;
   logic                r_err;
   logic                r_bus_req;
   logic                r_bus_we;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic [3:0]          r_bus_be;
   logic [DATA_W-1:0]   r_bus_wdata;
   logic [DATA_W-1:0]   r_rdata;

   logic                w_access;
   logic                w_is_byte;
   logic                w_is_half;
   logic                w_misaligned;
   logic [3:0]          w_be;
   logic [DATA_W-1:0]   w_wdata;
   logic [DATA_W-1:0]   w_shifted;
   logic [DATA_W-1:0]   w_load_data;

   assign w_access  = i_core_mem_read | i_core_mem_write;
   assign w_is_byte = (i_core_funct3[1:0] == 2'b00);
   assign w_is_half = (i_core_funct3[1:0] == 2'b01);
   // Any size encoding other than byte/half (including 011/11x) is a word
   assign w_misaligned = (w_is_half & i_core_addr[0]) |
                         (~w_is_byte & ~w_is_half & (i_core_addr[1:0] != 2'b00));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_core_wdata;
      if (w_is_byte) begin
         w_be    = 4'b0001 << i_core_addr[1:0];
         w_wdata = {4{i_core_wdata[7:0]}};
      end else if (w_is_half) begin
         w_be    = 4'b0011 << {i_core_addr[1], 1'b0};
         w_wdata = {2{i_core_wdata[15:0]}};
      end
   end

   always_comb begin
      w_shifted   = i_bus_rdata >> {r_offset, 3'b000};
      w_load_data = w_shifted;
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
         3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
         default: w_load_data = w_shifted;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_access) w_next = w_misaligned ? S_DONE : S_REQ;
         S_REQ:   if (i_bus_gnt) w_next = S_WAIT;
         S_WAIT:  if (i_bus_rvalid) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_offset    <= 2'd0;
         r_funct3    <= 3'd0;
         r_err       <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_be    <= 4'd0;
         r_bus_wdata <= '0;
         r_rdata     <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  r_offset <= i_core_addr[1:0];
                  r_funct3 <= i_core_funct3;
                  r_err    <= w_misaligned;
                  r_rdata  <= '0;
                  r_bus_we <= i_core_mem_write;
                  if (!w_misaligned) begin
                     r_bus_req   <= 1'b1;
                     r_bus_addr  <= {i_core_addr[ADDR_W-1:2], 2'b00};
                     r_bus_be    <= w_be;
                     r_bus_wdata <= w_wdata;
                  end
               end
            end
            S_REQ: begin
               if (i_bus_gnt) r_bus_req <= 1'b0;
            end
            S_WAIT: begin
               // Stores only use rvalid as an ack; their result stays zero
               if (i_bus_rvalid && !r_bus_we) r_rdata <= w_load_data;
            end
            S_DONE: begin
               r_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_core_stall = ~reset & w_access & (r_state != S_DONE);
   assign o_misalign   = (r_state == S_DONE) & r_err;
   assign o_core_rdata = r_rdata;
   assign o_bus_req    = r_bus_req;
   assign o_bus_we     = r_bus_we;
   assign o_bus_addr   = r_bus_addr;
   assign o_bus_be     = r_bus_be;
   assign o_bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bridge.sv
// Bench for lsu_bridge: directed access cases plus randomized accesses with a
// randomized bus responder, checked against an arithmetic reference model.
module tb_lsu_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_rd, core_wr;
   logic [2:0]  core_f3;
   logic [31:0] core_addr, core_wdata;
   logic [31:0] core_rdata;
   logic        core_stall, misalign;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_core_mem_read  (core_rd),
      .i_core_mem_write (core_wr),
      .i_core_funct3    (core_f3),
      .i_core_addr      (core_addr),
      .i_core_wdata     (core_wdata),
      .o_core_rdata     (core_rdata),
      .o_core_stall     (core_stall),
      .o_misalign       (misalign),
      .o_bus_req        (bus_req),
      .o_bus_we         (bus_we),
      .o_bus_addr       (bus_addr),
      .o_bus_be         (bus_be),
      .o_bus_wdata      (bus_wdata),
      .i_bus_gnt        (bus_gnt),
      .i_bus_rvalid     (bus_rvalid),
      .i_bus_rdata      (bus_rdata)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Runs one core access; entered just after a rising edge, leaves just after one.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
      int          size, exp_stall, n_stall, n_req, n_wait;
      logic [1:0]  a;
      logic        mis, gnt_given, done;
      logic [31:0] e_addr, e_wdata, e_rdata, v;
      logic [3:0]  e_be;

      a = addr[1:0];
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      mis     = (int'(a) % size) != 0;
      e_addr  = addr & 32'hFFFF_FFFC;
      e_be    = (size == 1) ? 4'(1 << a) : (size == 2) ? 4'(3 << a) : 4'hF;
      e_wdata = (size == 1) ? 32'(wdata[7:0]) * 32'h0101_0101 :
                (size == 2) ? 32'(wdata[15:0]) * 32'h0001_0001 : wdata;
      v = rdata >> (8 * int'(a));
      case (f3)
         3'd0:    e_rdata = v[7]  ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
         3'd4:    e_rdata = v & 32'h0000_00FF;
         3'd1:    e_rdata = v[15] ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
         3'd5:    e_rdata = v & 32'h0000_FFFF;
         default: e_rdata = v;
      endcase
      if (mis) e_rdata = 32'd0;
      exp_stall = mis ? 1 : 3 + gnt_dly + rv_dly;

      core_rd = rd; core_wr = wr; core_f3 = f3; core_addr = addr; core_wdata = wdata;
      n_stall = 0; n_req = 0; n_wait = 0; gnt_given = 1'b0; done = 1'b0;

      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
         if (core_stall) begin
            n_stall++;
            check_val("misalign_low_while_stalled", 32'(misalign), 32'd0);
            if (bus_req) begin
               n_req++;
               check_val("bus_addr", bus_addr, e_addr);
               check_val("bus_be", 32'(bus_be), 32'(e_be));
               check_val("bus_we", 32'(bus_we), 32'(wr));
               if (wr) check_val("bus_wdata", bus_wdata, e_wdata);
               if (n_req == gnt_dly + 1) begin
                  bus_gnt = 1'b1;
                  gnt_given = 1'b1;
               end
               bus_rvalid = 1'($urandom_range(0, 1));
            end else if (gnt_given) begin
               n_wait++;
               if (n_wait == rv_dly + 1) begin
                  bus_rvalid = 1'b1;
                  bus_rdata  = rdata;
               end else begin
                  bus_gnt = 1'($urandom_range(0, 1));
               end
            end else begin
               bus_gnt    = 1'($urandom_range(0, 1));
               bus_rvalid = 1'($urandom_range(0, 1));
            end
         end else begin
            done = 1'b1;
            check_val("stall_cycles", 32'(n_stall), 32'(exp_stall));
            check_val("req_cycles", 32'(n_req), mis ? 32'd0 : 32'(gnt_dly + 1));
            check_val("misalign_done", 32'(misalign), 32'(mis));
            if (!wr || mis) check_val("core_rdata", core_rdata, e_rdata);
         end
         @(posedge clk);
         #1;
      end
      if (!done) check_val("access_timeout", 32'd1, 32'd0);
      core_rd = 1'b0; core_wr = 1'b0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      core_rd = 1'b1; core_wr = 1'b0; core_f3 = 3'd2; core_addr = 32'h64; core_wdata = 32'd0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(negedge clk);
      check_val("rst_stall", 32'(core_stall), 32'd0);
      check_val("rst_bus_req", 32'(bus_req), 32'd0);
      check_val("rst_bus_we", 32'(bus_we), 32'd0);
      check_val("rst_bus_addr", bus_addr, 32'd0);
      check_val("rst_bus_be", 32'(bus_be), 32'd0);
      check_val("rst_bus_wdata", bus_wdata, 32'd0);
      check_val("rst_core_rdata", core_rdata, 32'd0);
      check_val("rst_misalign", 32'(misalign), 32'd0);
      core_rd = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      run_access(1, 0, 3'd2, 32'h64, 32'h0, 32'h1234_5678, 0, 0);   // lw
      run_access(1, 0, 3'd0, 32'h63, 32'h0, 32'h80FF_0000, 0, 0);   // lb
      run_access(1, 0, 3'd4, 32'h63, 32'h0, 32'h80FF_0000, 0, 0);   // lbu
      run_access(0, 1, 3'd1, 32'h62, 32'h0000_ABCD, 32'h0, 0, 0);   // sh
      run_access(0, 1, 3'd2, 32'h60, 32'hCAFE_F00D, 32'h0, 2, 1);   // sw with wait states
      run_access(1, 0, 3'd2, 32'h66, 32'h0, 32'hFFFF_FFFF, 0, 0);   // misaligned lw
      run_access(1, 0, 3'd5, 32'h102, 32'h0, 32'h9ABC_1234, 1, 2);  // lhu upper half
      run_access(1, 0, 3'd1, 32'h102, 32'h0, 32'h9ABC_1234, 0, 0);  // lh upper half
      run_access(1, 1, 3'd0, 32'h41, 32'h0000_005A, 32'h0, 0, 0);   // both asserted: store

      // Reset while in WAIT, then a stray rvalid for the abandoned load
      core_rd = 1'b1; core_wr = 1'b0; core_f3 = 3'd2; core_addr = 32'h64;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("rstw_req_before", 32'(bus_req), 32'd1);
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      @(negedge clk);
      check_val("rstw_in_wait", 32'(core_stall), 32'd1);
      reset = 1'b1;
      #1;
      check_val("rstw_bus_req", 32'(bus_req), 32'd0);
      check_val("rstw_stall", 32'(core_stall), 32'd0);
      core_rd = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus_rvalid = 1'b0;
      check_val("rstw_rdata_after_stray", core_rdata, 32'd0);
      check_val("rstw_req_after_stray", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      run_access(1, 0, 3'd2, 32'h64, 32'h0, 32'h0BAD_F00D, 0, 0);

      for (int i = 0; i < 40; i++) begin
         int          k;
         logic [31:0] addr;
         k    = $urandom_range(0, 2);
         addr = $urandom;
         run_access(k != 1, k != 0, 3'($urandom_range(0, 7)), addr, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
